// File: rtl/sa_cache_pkg.sv
// rtl/sa_cache_pkg.sv - shared sizing, request encoding and bridge state enum for sa_cache
package sa_cache_pkg;

   localparam int ADDR_W     = 32;
   localparam int WORD_W     = 32;
   localparam int LINE_WORDS = 4;
   localparam int OFF_W      = $clog2(LINE_WORDS * WORD_W / 8);
   localparam int BEAT_W     = $clog2(LINE_WORDS);

   localparam logic REQ_FILL = 1'b0;
   localparam logic REQ_WB   = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } state_t;

endpackage

// File: rtl/cache_mem_bridge.sv
// rtl/cache_mem_bridge.sv - line-fill / write-back engine serialising whole cache lines into memory beats
module cache_mem_bridge #(
   parameter  int ADDR_W     = sa_cache_pkg::ADDR_W,
   parameter  int WORD_W     = sa_cache_pkg::WORD_W,
   parameter  int LINE_WORDS = sa_cache_pkg::LINE_WORDS,
   localparam int OFF_W      = $clog2(LINE_WORDS * WORD_W / 8),
   localparam int BEAT_W     = $clog2(LINE_WORDS),
   localparam int BYTE_W     = $clog2(WORD_W / 8),
   localparam int LINE_W     = LINE_WORDS * WORD_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_req,
   input  logic                    i_rw,
   input  logic [ADDR_W-OFF_W-1:0] i_line_addr,
   input  logic [LINE_W-1:0]       i_wline,
   output logic                    o_busy,
   output logic                    o_memory_response,
   output logic [LINE_W-1:0]       o_memory_line,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [WORD_W-1:0]       mem_wdata,
   input  logic                    mem_ready,
   input  logic [WORD_W-1:0]       mem_rdata
);
   import sa_cache_pkg::*;

   state_t                  state, state_nx;
   logic [ADDR_W-OFF_W-1:0] line_addr_q;
   logic                    rw_q;
   logic [LINE_W-1:0]       wline_q;
   logic [LINE_W-1:0]       asm_q, asm_nx;
   logic [BEAT_W-1:0]       beat;
   logic                    accept, hs, last;

   assign accept = (state == IDLE) && i_req;
   assign hs     = mem_req && mem_ready;
   assign last   = (beat == BEAT_W'(LINE_WORDS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (i_req) state_nx = (i_rw == REQ_WB) ? WR : RD;
         RD, WR:  if (hs && last) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Bus outputs decode purely from state so an async reset drops mem_req at once.
   always_comb begin
      o_busy            = 1'b0;
      o_memory_response = 1'b0;
      mem_req           = 1'b0;
      mem_we            = 1'b0;
      mem_addr          = '0;
      mem_wdata         = '0;
      case (state)
         RD: begin
            o_busy   = 1'b1;
            mem_req  = 1'b1;
            mem_addr = {line_addr_q, beat, {BYTE_W{1'b0}}};
         end
         WR: begin
            o_busy    = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {line_addr_q, beat, {BYTE_W{1'b0}}};
            mem_wdata = wline_q[beat*WORD_W +: WORD_W];
         end
         RESP: begin
            o_busy            = 1'b1;
            o_memory_response = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      asm_nx = asm_q;
      asm_nx[beat*WORD_W +: WORD_W] = mem_rdata;
   end

   // The final word is merged on the way into o_memory_line so it is valid alongside the pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_addr_q   <= '0;
         rw_q          <= REQ_FILL;
         wline_q       <= '0;
         asm_q         <= '0;
         beat          <= '0;
         o_memory_line <= '0;
      end else begin
         if (accept) begin
            line_addr_q <= i_line_addr;
            rw_q        <= i_rw;
            wline_q     <= i_wline;
            beat        <= '0;
         end else if (hs) begin
            beat <= beat + 1'b1;
         end
         if (hs && rw_q == REQ_FILL)
            asm_q <= asm_nx;
         if (hs && last && rw_q == REQ_FILL)
            o_memory_line <= asm_nx;
      end
   end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// tb/tb_cache_mem_bridge.sv - directed self-checking bench for cache_mem_bridge
module tb_cache_mem_bridge;
   import sa_cache_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req, i_rw;
   logic [27:0]   i_line_addr;
   logic [127:0]  i_wline;
   logic          o_busy, o_memory_response;
   logic [127:0]  o_memory_line;
   logic          mem_req, mem_we;
   logic [31:0]   mem_addr, mem_wdata;
   logic          mem_ready;
   logic [31:0]   mem_rdata;

   int checks = 0;
   int errors = 0;
   int req_cnt, resp_cnt;
   int wb_rdy[6] = '{1, 0, 0, 1, 1, 1};
   int wb_idx[6] = '{0, 1, 1, 1, 2, 3};

   localparam logic [127:0] FILL_A = 128'h000000A3_000000A2_000000A1_000000A0;
   localparam logic [127:0] FILL_B = 128'h000000B3_000000B2_000000B1_000000B0;
   localparam logic [127:0] FILL_D = 128'h000000D3_000000D2_000000D1_000000D0;

   always #5 clk = ~clk;

   cache_mem_bridge dut (
      .clk               (clk),
      .rst               (rst),
      .i_req             (i_req),
      .i_rw              (i_rw),
      .i_line_addr       (i_line_addr),
      .i_wline           (i_wline),
      .o_busy            (o_busy),
      .o_memory_response (o_memory_response),
      .o_memory_line     (o_memory_line),
      .mem_req           (mem_req),
      .mem_we            (mem_we),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .mem_ready         (mem_ready),
      .mem_rdata         (mem_rdata)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; i_req = 1'b0; i_rw = REQ_FILL; i_line_addr = '0; i_wline = '0;
      mem_ready = 1'b0; mem_rdata = '0;

      // reset values
      sample();
      chk1("rst_busy", o_busy, 1'b0);
      chk1("rst_resp", o_memory_response, 1'b0);
      chk128("rst_line", o_memory_line, '0);
      chk1("rst_req", mem_req, 1'b0);
      chk1("rst_we", mem_we, 1'b0);
      chk32("rst_addr", mem_addr, 32'h0);
      chk32("rst_wdata", mem_wdata, 32'h0);
      next_cycle();
      rst = 1'b0;
      sample();
      chk1("post_rst_busy", o_busy, 1'b0);
      chk1("post_rst_req", mem_req, 1'b0);
      next_cycle();

      // fill without stalls
      i_req = 1'b1; i_rw = REQ_FILL; i_line_addr = 28'h0000123; mem_ready = 1'b1;
      next_cycle();
      i_req = 1'b0; i_line_addr = 28'hFFFFFFF;
      for (int k = 0; k < 4; k++) begin
         mem_rdata = 32'hA0 + k;
         sample();
         chk1("fill_req", mem_req, 1'b1);
         chk1("fill_we", mem_we, 1'b0);
         chk32("fill_addr", mem_addr, 32'h1230 + 4 * k);
         chk1("fill_busy", o_busy, 1'b1);
         chk1("fill_noresp", o_memory_response, 1'b0);
         next_cycle();
      end
      sample();
      chk1("fill_resp", o_memory_response, 1'b1);
      chk128("fill_line", o_memory_line, FILL_A);
      chk1("fill_resp_busy", o_busy, 1'b1);
      chk1("fill_resp_noreq", mem_req, 1'b0);
      next_cycle();
      sample();
      chk1("fill_idle_busy", o_busy, 1'b0);
      chk1("fill_idle_resp", o_memory_response, 1'b0);
      chk128("fill_line_hold", o_memory_line, FILL_A);
      next_cycle();

      // write-back with a two-cycle stall on beat 1
      i_req = 1'b1; i_rw = REQ_WB; i_line_addr = 28'h0000456;
      i_wline = 128'h44444444_33333333_22222222_11111111; mem_ready = 1'b1;
      next_cycle();
      i_req = 1'b0; i_wline = '1;
      for (int c = 0; c < 6; c++) begin
         mem_ready = (wb_rdy[c] != 0);
         sample();
         chk1("wb_req", mem_req, 1'b1);
         chk1("wb_we", mem_we, 1'b1);
         chk32("wb_addr", mem_addr, 32'h4560 + 4 * wb_idx[c]);
         chk32("wb_wdata", mem_wdata, 32'h11111111 * (wb_idx[c] + 1));
         chk1("wb_noresp", o_memory_response, 1'b0);
         next_cycle();
      end
      mem_ready = 1'b1;
      sample();
      chk1("wb_resp", o_memory_response, 1'b1);
      chk1("wb_resp_noreq", mem_req, 1'b0);
      chk128("wb_line_unchanged", o_memory_line, FILL_A);
      next_cycle();

      // request while busy is dropped
      i_req = 1'b1; i_rw = REQ_FILL; i_line_addr = 28'h0000789;
      next_cycle();
      i_req = 1'b0;
      req_cnt = 0; resp_cnt = 0;
      for (int c = 1; c <= 10; c++) begin
         mem_rdata = 32'hB0 + (c - 1);
         i_req = (c == 3);
         i_rw = REQ_WB;
         sample();
         req_cnt += int'(mem_req);
         resp_cnt += int'(o_memory_response);
         next_cycle();
      end
      i_req = 1'b0;
      chk32("busy_req_beats", req_cnt, 32'd4);
      chk32("busy_req_resps", resp_cnt, 32'd1);
      chk128("busy_req_line", o_memory_line, FILL_B);
      chk1("busy_req_idle", o_busy, 1'b0);

      // reset in the middle of a fill
      i_req = 1'b1; i_rw = REQ_FILL; i_line_addr = 28'h0000ABC;
      next_cycle();
      i_req = 1'b0;
      mem_rdata = 32'hC0;
      next_cycle();
      mem_rdata = 32'hC1;
      next_cycle();
      mem_rdata = 32'hC2;
      rst = 1'b1;
      #1;
      chk1("midrst_req", mem_req, 1'b0);
      chk1("midrst_busy", o_busy, 1'b0);
      chk1("midrst_resp", o_memory_response, 1'b0);
      chk1("midrst_we", mem_we, 1'b0);
      chk32("midrst_addr", mem_addr, 32'h0);
      chk128("midrst_line", o_memory_line, '0);
      next_cycle();
      rst = 1'b0;
      req_cnt = 0; resp_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         sample();
         req_cnt += int'(mem_req);
         resp_cnt += int'(o_memory_response) + int'(o_busy);
         next_cycle();
      end
      chk32("midrst_no_beats", req_cnt, 32'd0);
      chk32("midrst_no_resp", resp_cnt, 32'd0);
      chk128("midrst_line_after", o_memory_line, '0);

      // fill then write-back with i_req held high
      i_req = 1'b1; i_rw = REQ_FILL; i_line_addr = 28'h0000DEF;
      next_cycle();
      i_rw = REQ_WB; i_wline = 128'h88888888_77777777_66666666_55555555;
      resp_cnt = 0;
      for (int c = 1; c <= 12; c++) begin
         mem_rdata = 32'hD0 + (c - 1);
         i_req = (c < 7);
         sample();
         resp_cnt += int'(o_memory_response);
         if (c == 5) begin
            chk1("b2b_fill_resp", o_memory_response, 1'b1);
            chk128("b2b_fill_line", o_memory_line, FILL_D);
         end
         if (c == 6) begin
            chk1("b2b_gap_busy", o_busy, 1'b0);
            chk1("b2b_gap_req", mem_req, 1'b0);
         end
         if (c == 7) begin
            chk1("b2b_wb_req", mem_req, 1'b1);
            chk1("b2b_wb_we", mem_we, 1'b1);
            chk32("b2b_wb_addr", mem_addr, 32'hDEF0);
            chk32("b2b_wb_wdata", mem_wdata, 32'h55555555);
         end
         if (c == 10)
            chk32("b2b_wb_last_wdata", mem_wdata, 32'h88888888);
         if (c == 11) begin
            chk1("b2b_wb_resp", o_memory_response, 1'b1);
            chk128("b2b_wb_line", o_memory_line, FILL_D);
         end
         next_cycle();
      end
      chk32("b2b_resp_count", resp_cnt, 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
